// File: rtl/fetch_unit.sv
// fetch_unit: single-port bus master between the core FSM and the W-bus.
// It takes one read or write request at a time from the core, runs the
// W-bus transaction and returns read data with a one-cycle ack pulse.
// Bus-side progress happens only on clk edges where the W_CLK phase enable is high.
//
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a transaction
// with no W_ACK ends after TIMEOUT W_CLK-qualified wait edges. A read that ends
// this way returns ERR_DATA.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   W_RST        in   asynchronous active-high reset
//   enable       in   core request (level-sensitive)
//   write_enable in   1 = write, 0 = read
//   addr         in   [31:0] core word address
//   data_i       in   [31:0] write data
//   thread       in   [1:0] thread id, adds (thread << THREAD_SHIFT) to addr
//   data_o       out  [31:0] read data, held until the next read completes
//   ack          out  one-cycle completion pulse
//   W_CLK        in   bus phase enable
//   W_ACK        in   bus slave acknowledge
//   W_DATA_I     in   [31:0] bus read data
//   W_DATA_O     out  [31:0] bus write data
//   W_ADDR       out  [31:0] bus address
//   W_WRITE      out  bus write qualifier
//   W_STB        out  bus strobe, high for the whole transaction
//   state_o      out  [1:0] debug view of the FSM state (0 idle, 1 wait, 2 done)
//
// Core handshake: enable is a level request. It is captured in IDLE on any clk edge.
// Completion is signalled by a single ack cycle. The following DONE cycle ignores
// enable so the core has time to drop it.
module fetch_unit #(
`ifdef FETCH_TIMEOUT_EN
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
`endif
  parameter int          THREAD_SHIFT = 24
) (
  input  logic        clk,
  input  logic        W_RST,
  input  logic        enable,
  input  logic        write_enable,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  input  logic [1:0]  thread,
  output logic [31:0] data_o,
  output logic        ack,
  input  logic        W_CLK,
  input  logic        W_ACK,
  input  logic [31:0] W_DATA_I,
  output logic [31:0] W_DATA_O,
  output logic [31:0] W_ADDR,
  output logic        W_WRITE,
  output logic        W_STB,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] addr_d;

  // Per-thread offset; the 32-bit sum wraps naturally.
  assign addr_d  = addr + ({30'd0, thread} << THREAD_SHIFT);
  assign state_o = state_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          tmo_hit;
  // The counter holds the number of earlier qualified edges without W_ACK.
  // The edge that would bring it to TIMEOUT ends the transaction.
  assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or posedge W_RST) begin
    if (W_RST) begin
      state_q  <= S_IDLE;
      data_o   <= 32'd0;
      ack      <= 1'b0;
      W_DATA_O <= 32'd0;
      W_ADDR   <= 32'd0;
      W_WRITE  <= 1'b0;
      W_STB    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      ack <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Request capture does not depend on W_CLK.
          if (enable) begin
            W_WRITE  <= write_enable;
            W_DATA_O <= data_i;
            W_ADDR   <= addr_d;
            W_STB    <= 1'b1;
            state_q  <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (W_CLK) begin
            // If W_ACK and the timeout fall on the same edge, W_ACK wins.
            if (W_ACK) begin
              if (!W_WRITE) data_o <= W_DATA_I;
              ack     <= 1'b1;
              W_STB   <= 1'b0;
              W_WRITE <= 1'b0;
              state_q <= S_DONE;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (tmo_hit) begin
              if (!W_WRITE) data_o <= ERR_DATA;
              ack     <= 1'b1;
              W_STB   <= 1'b0;
              W_WRITE <= 1'b0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO = 4;
`endif
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        W_RST;
  logic        enable, write_enable;
  logic [31:0] addr, data_i;
  logic [1:0]  thread;
  logic [31:0] data_o;
  logic        ack;
  logic        W_CLK, W_ACK;
  logic [31:0] W_DATA_I, W_DATA_O, W_ADDR;
  logic        W_WRITE, W_STB;
  logic [1:0]  state_o;

  fetch_unit #(
`ifdef FETCH_TIMEOUT_EN
    .TIMEOUT(TMO),
    .ERR_DATA(ERR),
`endif
    .THREAD_SHIFT(24)
  ) dut (
    .clk(clk), .W_RST(W_RST), .enable(enable), .write_enable(write_enable),
    .addr(addr), .data_i(data_i), .thread(thread), .data_o(data_o), .ack(ack),
    .W_CLK(W_CLK), .W_ACK(W_ACK), .W_DATA_I(W_DATA_I), .W_DATA_O(W_DATA_O),
    .W_ADDR(W_ADDR), .W_WRITE(W_WRITE), .W_STB(W_STB), .state_o(state_o)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard state
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_data = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference address: core address plus thread * 2^24, modulo 2^32
  function automatic logic [31:0] ref_addr(input logic [31:0] a, input logic [1:0] th);
    logic [63:0] s;
    s = 64'(a) + 64'(th) * 64'd16777216;
    return s[31:0];
  endfunction

  // One transaction. pat: 0 random bus, 1 W_CLK gated for 3 edges, 2 no W_ACK, 3 ack at once.
  // With hold set, enable stays high afterwards and the task ends after the DONE edge.
  task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] th, input logic [31:0] rdata, input int pat,
                        input bit hold, output int ack_cyc);
    bit   done;
    logic wc, wa;
`ifdef FETCH_TIMEOUT_EN
    int   qn;
    qn = 0;
`endif
    done    = 1'b0;
    ack_cyc = 0;
    enable = 1'b1; write_enable = we; addr = a; data_i = d; thread = th;
    W_ACK = 1'b0; W_CLK = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("stb_req", {31'd0, W_STB}, 32'd1);
    chk("addr_req", W_ADDR, ref_addr(a, th));
    chk("write_req", {31'd0, W_WRITE}, {31'd0, we});
    if (we) chk("wdata_req", W_DATA_O, d);
    chk("ack_req", {31'd0, ack}, 32'd0);
    if (!hold) begin
      // Inputs changing during the wait must not disturb the latched request.
      enable = 1'b0; addr = $urandom; data_i = $urandom; write_enable = ~we;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      case (pat)
        0: begin
          wc = (i >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
          wa = (i >= 12) ? 1'b1 : ($urandom_range(0, 3) == 0);
        end
        1: begin wc = (i >= 3); wa = 1'b1; end
        2: begin wc = 1'b1; wa = 1'b0; end
        default: begin wc = 1'b1; wa = 1'b1; end
      endcase
      W_CLK = wc; W_ACK = wa; W_DATA_I = wa ? rdata : $urandom;
      @(posedge clk); #1;
      if (wc && wa) begin
        done = 1'b1;
        exp_q.push_back(we ? model_data : rdata);
      end
`ifdef FETCH_TIMEOUT_EN
      else if (wc) begin
        qn++;
        if (qn == TMO) begin
          done = 1'b1;
          exp_q.push_back(we ? model_data : ERR);
        end
      end
`endif
      if (done) begin
        model_data = exp_q.pop_front();
        chk("ack_end", {31'd0, ack}, 32'd1);
        chk("stb_end", {31'd0, W_STB}, 32'd0);
        chk("write_end", {31'd0, W_WRITE}, 32'd0);
        chk("data_o_end", data_o, model_data);
        ack_cyc = cyc;
      end else begin
        chk("ack_wait", {31'd0, ack}, 32'd0);
        chk("stb_wait", {31'd0, W_STB}, 32'd1);
      end
    end
    chk("completed_in_bound", {31'd0, done}, 32'd1);
    W_ACK = 1'b0; W_CLK = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("ack_done", {31'd0, ack}, 32'd0);
    chk("stb_done", {31'd0, W_STB}, 32'd0);
    chk("addr_hold", W_ADDR, ref_addr(a, th));
    chk("data_o_hold", data_o, model_data);
    if (!hold) begin
      @(posedge clk); #1;
      chk("stb_idle", {31'd0, W_STB}, 32'd0);
      chk("ack_idle", {31'd0, ack}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data_o"}, data_o, 32'd0);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
    chk({tag, "_wdata"}, W_DATA_O, 32'd0);
    chk({tag, "_waddr"}, W_ADDR, 32'd0);
    chk({tag, "_write"}, {31'd0, W_WRITE}, 32'd0);
    chk({tag, "_stb"}, {31'd0, W_STB}, 32'd0);
  endtask

  initial begin
    int c1, c2;
    logic [31:0] a;
    W_RST = 1'b1; enable = 1'b0; write_enable = 1'b0; addr = 32'd0; data_i = 32'd0;
    thread = 2'd0; W_CLK = 1'b0; W_ACK = 1'b0; W_DATA_I = 32'd0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("rst");
    @(negedge clk) W_RST = 1'b0;

    // Read at 0x10 with an immediate bus ack, then a write with thread offset
    do_txn(1'b0, 32'h10, 32'd0, 2'd0, 32'hCAFE0001, 3, 1'b0, c1);
    chk("read_data", data_o, 32'hCAFE0001);
    do_txn(1'b1, 32'h4, 32'h55AA55AA, 2'd2, 32'h12345678, 3, 1'b0, c1);
    chk("write_addr", W_ADDR, 32'h02000004);
    chk("write_wdata", W_DATA_O, 32'h55AA55AA);
    chk("write_keeps_data_o", data_o, 32'hCAFE0001);

    // Address wrap-around
    do_txn(1'b0, 32'hFFFFFFFF, 32'd0, 2'd1, 32'h0BAD0BAD, 0, 1'b0, c1);
    chk("wrap_addr", W_ADDR, 32'h00FFFFFF);

    // W_ACK held while W_CLK is low for three edges
    do_txn(1'b0, 32'h200, 32'd0, 2'd3, 32'hA5A50001, 1, 1'b0, c1);

    // Held enable: DONE ignores it, then the same address is requested again
    a = 32'h300;
    do_txn(1'b0, a, 32'd0, 2'd1, 32'h11110000, 3, 1'b1, c1);
    @(posedge clk); #1;
    chk("held_restart_stb", {31'd0, W_STB}, 32'd1);
    chk("held_restart_addr", W_ADDR, ref_addr(a, 2'd1));
    enable = 1'b0; W_CLK = 1'b1; W_ACK = 1'b1; W_DATA_I = 32'h22220000;
    @(posedge clk); #1;
    c2 = cyc;
    chk("held_ack2", {31'd0, ack}, 32'd1);
    chk("held_data2", data_o, 32'h22220000);
    chk("held_spacing", 32'(c2 - c1), 32'd3);
    model_data = 32'h22220000;
    W_ACK = 1'b0;
    repeat (2) @(posedge clk);

`ifdef FETCH_TIMEOUT_EN
    // Read with no bus ack ends with the error word
    do_txn(1'b0, 32'h400, 32'd0, 2'd0, 32'h0, 2, 1'b0, c1);
    chk("timeout_data", data_o, ERR);
`endif

    // Randomized transactions
    for (int n = 0; n < 30; n++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
             $urandom, 0, 1'b0, c1);
    end

    // Reset in the middle of a wait aborts the transaction with no ack
    enable = 1'b1; write_enable = 1'b0; addr = 32'h500; thread = 2'd1;
    W_CLK = 1'b0; W_ACK = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_stb", {31'd0, W_STB}, 32'd1);
    enable = 1'b0;
    #3 W_RST = 1'b1;
    #1 check_all_zero("midrst");
    model_data = 32'd0;
    W_CLK = 1'b1; W_ACK = 1'b1; W_DATA_I = 32'hFFFF0000;
    @(negedge clk) W_RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_ack", {31'd0, ack}, 32'd0);
      chk("post_rst_stb", {31'd0, W_STB}, 32'd0);
      chk("post_rst_data", data_o, model_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
